// File: rtl/fetch_unit.sv
// Instruction fetch unit: program counter, single-outstanding memory read and instruction register.
// Optional FETCH_TIMEOUT_EN adds a 16-cycle read watchdog and a sticky fetch_fault output.

// state  | meaning
// S_IDLE | no read outstanding; accepts do_fetch and applies do_next directly
// S_WAIT | read outstanding; mem_req/mem_addr held until mem_ack, do_next deferred
module fetch_unit #(
    parameter int ADDR_WIDTH     = 8,
    parameter int INSTR_WIDTH    = 16,
    parameter int OPCODE_SIZE    = 4,
    parameter int ALU_OPCODE_MAX = 7,
    parameter logic [OPCODE_SIZE-1:0] HALT_OPCODE = 4'hF
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   do_fetch,
    input  logic                   do_next,
    input  logic                   do_reset,
    input  logic                   do_halt,
    input  logic                   branch_taken,
    input  logic [ADDR_WIDTH-1:0]  branch_target,
    output logic                   mem_req,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic                   mem_ack,
    input  logic [INSTR_WIDTH-1:0] mem_rdata,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [OPCODE_SIZE-1:0] opcode,
    output logic                   is_alu_operation,
    output logic                   instr_valid,
    output logic [ADDR_WIDTH-1:0]  pc,
    output logic                   fetch_stall
`ifdef FETCH_TIMEOUT_EN
    ,
    output logic                   fetch_fault
`endif
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [OPCODE_SIZE-1:0] ALU_MAX = OPCODE_SIZE'(ALU_OPCODE_MAX);

    state_t                state, state_nxt;
    logic                  pending;
    logic [ADDR_WIDTH-1:0] pending_pc;
    logic [ADDR_WIDTH-1:0] next_pc;
    logic                  start_fetch;
    logic                  timeout;

`ifdef FETCH_TIMEOUT_EN
    logic [3:0] tmo_cnt;
    assign timeout = (state == S_WAIT) && !mem_ack && (tmo_cnt == 4'd0);
`else
    assign timeout = 1'b0;
`endif

    assign next_pc     = branch_taken ? branch_target : pc + ADDR_WIDTH'(1);
    assign start_fetch = (state == S_IDLE) && do_fetch && !do_halt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (do_reset) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (start_fetch) state_nxt = S_WAIT;
                S_WAIT: if (mem_ack || timeout) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        opcode           = instr[INSTR_WIDTH-1 -: OPCODE_SIZE];
        is_alu_operation = instr_valid && (opcode <= ALU_MAX);
        fetch_stall      = (state == S_WAIT);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            pending     <= 1'b0;
            pending_pc  <= '0;
        end else if (do_reset) begin
            pc          <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            mem_req     <= 1'b0;
            pending     <= 1'b0;
        end else if (state == S_IDLE) begin
            if (start_fetch) begin
                mem_req  <= 1'b1;
                mem_addr <= pc;
            end
            if (do_next) begin
                pc          <= next_pc;
                instr_valid <= 1'b0;
            end
        end else if (mem_ack) begin
            // The fetched word is loaded first; a deferred or coincident advance then invalidates it.
            instr   <= mem_rdata;
            mem_req <= 1'b0;
            pending <= 1'b0;
            if (pending) begin
                pc          <= pending_pc;
                instr_valid <= 1'b0;
            end else if (do_next) begin
                pc          <= next_pc;
                instr_valid <= 1'b0;
            end else begin
                instr_valid <= 1'b1;
            end
        end else if (timeout) begin
            // A deferred advance is dropped so the injected halt word stays visible as valid.
            mem_req     <= 1'b0;
            instr       <= {HALT_OPCODE, {(INSTR_WIDTH-OPCODE_SIZE){1'b0}}};
            instr_valid <= 1'b1;
            pending     <= 1'b0;
        end else if (do_next && !pending) begin
            pending    <= 1'b1;
            pending_pc <= next_pc;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt     <= 4'd0;
            fetch_fault <= 1'b0;
        end else if (do_reset) begin
            tmo_cnt     <= 4'd0;
            fetch_fault <= 1'b0;
        end else begin
            if (start_fetch)
                tmo_cnt <= 4'hF;
            else if (state == S_WAIT && !mem_ack && tmo_cnt != 4'd0)
                tmo_cnt <= tmo_cnt - 4'd1;
            if (timeout)
                fetch_fault <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; build with FETCH_TIMEOUT_EN to cover the watchdog.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        do_fetch, do_next, do_reset, do_halt, branch_taken;
    logic [7:0]  branch_target;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] instr;
    logic [3:0]  opcode;
    logic        is_alu_operation, instr_valid, fetch_stall;
    logic [7:0]  pc;
`ifdef FETCH_TIMEOUT_EN
    logic        fetch_fault;
`endif

    int total = 0;
    int bad   = 0;

    fetch_unit dut (
        .clock(clock), .reset_n(reset_n),
        .do_fetch(do_fetch), .do_next(do_next), .do_reset(do_reset), .do_halt(do_halt),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr(instr), .opcode(opcode), .is_alu_operation(is_alu_operation),
        .instr_valid(instr_valid), .pc(pc), .fetch_stall(fetch_stall)
`ifdef FETCH_TIMEOUT_EN
        , .fetch_fault(fetch_fault)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_pc(input logic [7:0] v);
        do_next = 1'b1; branch_taken = 1'b1; branch_target = v;
        tick();
        do_next = 1'b0; branch_taken = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; do_fetch = 0; do_next = 0; do_reset = 0; do_halt = 0;
        branch_taken = 0; branch_target = '0; mem_ack = 0; mem_rdata = '0;
        #12;
        chk("rst_pc", pc, 0);
        chk("rst_instr", instr, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_stall", fetch_stall, 0);
        reset_n = 1'b1;
        tick();

        // basic fetch, ack after 2 cycles in WAIT
        do_fetch = 1'b1;
        tick();
        do_fetch = 1'b0;
        chk("f1_req", mem_req, 1);
        chk("f1_addr_c1", mem_addr, 0);
        chk("f1_stall", fetch_stall, 1);
        tick();
        chk("f1_addr_c2", mem_addr, 0);
        mem_ack = 1'b1; mem_rdata = 16'h3012;
        chk("f1_addr_c3", mem_addr, 0);
        tick();
        mem_ack = 1'b0;
        chk("f1_instr", instr, 16'h3012);
        chk("f1_opcode", opcode, 3);
        chk("f1_alu", is_alu_operation, 1);
        chk("f1_valid", instr_valid, 1);
        chk("f1_req_off", mem_req, 0);
        chk("f1_stall_off", fetch_stall, 0);

        // ack in IDLE ignored
        mem_ack = 1'b1; mem_rdata = 16'hFFFF;
        tick();
        mem_ack = 1'b0;
        chk("idle_ack_instr", instr, 16'h3012);
        chk("idle_ack_stall", fetch_stall, 0);

        // sequential advance and wrap
        do_next = 1'b1;
        tick();
        do_next = 1'b0;
        chk("next_pc", pc, 8'h01);
        chk("next_valid", instr_valid, 0);
        chk("next_alu", is_alu_operation, 0);
        set_pc(8'hFF);
        chk("branch_pc", pc, 8'hFF);
        do_next = 1'b1;
        tick();
        do_next = 1'b0;
        chk("wrap_pc", pc, 8'h00);
        chk("wrap_valid", instr_valid, 0);

        // halt blocks new requests
        do_halt = 1'b1; do_fetch = 1'b1;
        tick();
        do_halt = 1'b0; do_fetch = 1'b0;
        chk("halt_req", mem_req, 0);
        chk("halt_stall", fetch_stall, 0);

        // deferred branch during WAIT; halt and a second fetch strobe during WAIT
        set_pc(8'h05);
        do_fetch = 1'b1;
        tick();
        chk("w_addr", mem_addr, 8'h05);
        do_next = 1'b1; branch_taken = 1'b1; branch_target = 8'h40; do_halt = 1'b1;
        tick();
        do_next = 1'b0; branch_taken = 1'b0; do_fetch = 1'b0;
        chk("w_pc_held", pc, 8'h05);
        chk("w_req_held", mem_req, 1);
        tick();
        chk("w_addr_held", mem_addr, 8'h05);
        tick();
        mem_ack = 1'b1; mem_rdata = 16'hA123;
        tick();
        mem_ack = 1'b0; do_halt = 1'b0;
        chk("w_instr", instr, 16'hA123);
        chk("w_opcode", opcode, 4'hA);
        chk("w_pc_applied", pc, 8'h40);
        chk("w_valid", instr_valid, 0);
        chk("w_req_off", mem_req, 0);

        // do_reset coincident with ack
        do_fetch = 1'b1;
        tick();
        do_fetch = 1'b0;
        chk("r_addr", mem_addr, 8'h40);
        mem_ack = 1'b1; mem_rdata = 16'h1234; do_reset = 1'b1;
        tick();
        mem_ack = 1'b0; do_reset = 1'b0;
        chk("r_instr", instr, 0);
        chk("r_pc", pc, 0);
        chk("r_req", mem_req, 0);
        chk("r_valid", instr_valid, 0);
        chk("r_stall", fetch_stall, 0);

        // do_reset must also drop a deferred advance
        do_fetch = 1'b1;
        tick();
        do_fetch = 1'b0;
        do_next = 1'b1; branch_taken = 1'b1; branch_target = 8'h77;
        tick();
        do_next = 1'b0; branch_taken = 1'b0; do_reset = 1'b1;
        tick();
        do_reset = 1'b0; do_fetch = 1'b1;
        tick();
        do_fetch = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h8001;
        tick();
        mem_ack = 1'b0;
        chk("rp_pc", pc, 0);
        chk("rp_valid", instr_valid, 1);
        chk("rp_alu", is_alu_operation, 0);

        // asynchronous reset mid-read
        set_pc(8'h22);
        do_fetch = 1'b1;
        tick();
        do_fetch = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("ar_req", mem_req, 0);
        chk("ar_pc", pc, 0);
        chk("ar_addr", mem_addr, 0);
        chk("ar_stall", fetch_stall, 0);
        chk("ar_instr", instr, 0);
        reset_n = 1'b1;
        tick();

`ifdef FETCH_TIMEOUT_EN
        chk("t_fault_rst", fetch_fault, 0);
        do_fetch = 1'b1;
        tick();
        do_fetch = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("t_req_15", mem_req, 1);
        chk("t_fault_15", fetch_fault, 0);
        tick();
        chk("t_fault", fetch_fault, 1);
        chk("t_opcode", opcode, 4'hF);
        chk("t_instr", instr, 16'hF000);
        chk("t_req", mem_req, 0);
        chk("t_valid", instr_valid, 1);
        chk("t_stall", fetch_stall, 0);
        tick();
        chk("t_sticky", fetch_fault, 1);
        do_reset = 1'b1;
        tick();
        do_reset = 1'b0;
        chk("t_clear", fetch_fault, 0);
`else
        do_fetch = 1'b1;
        tick();
        do_fetch = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        chk("nt_req", mem_req, 1);
        chk("nt_stall", fetch_stall, 1);
        do_reset = 1'b1;
        tick();
        do_reset = 1'b0;
        chk("nt_req_off", mem_req, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 8: program counter and instruction-memory address width.
REQ-002 Parameter INSTR_WIDTH, default 16: instruction word width.
REQ-003 Parameter OPCODE_SIZE, default 4: opcode field width, taken from instr[INSTR_WIDTH-1 -: OPCODE_SIZE].
REQ-004 Parameter ALU_OPCODE_MAX, default 7: opcodes 0..ALU_OPCODE_MAX are ALU operations.
REQ-005 Parameter HALT_OPCODE, default 4'hF: opcode injected on fetch fault.
REQ-006 Ports SHALL be:
  clock  in  1  system clock, rising edge.
  reset_n  in  1  asynchronous active-low reset.
  do_fetch  in  1  fetch strobe from control.
  do_next  in  1  advance-PC strobe from control.
  do_reset  in  1  synchronous soft reset from control.
  do_halt  in  1  control halted.
  branch_taken  in  1  branch condition resolved true, sampled with do_next.
  branch_target  in  ADDR_WIDTH  branch destination.
  mem_req  out  1  instruction-memory read request.
  mem_addr  out  ADDR_WIDTH  read address.
  mem_ack  in  1  read data valid.
  mem_rdata  in  INSTR_WIDTH  read data.
  instr  out  INSTR_WIDTH  instruction register.
  opcode  out  OPCODE_SIZE  decoded opcode.
  is_alu_operation  out  1  opcode is an ALU operation.
  instr_valid  out  1  instr holds the instruction at pc.
  pc  out  ADDR_WIDTH  program counter.
  fetch_stall  out  1  read outstanding; top level uses it to freeze the control clock enable.

Function
REQ-007 States SHALL be IDLE and WAIT.
REQ-008 In IDLE, do_fetch with do_halt low SHALL, on the next edge: set mem_req=1, mem_addr=pc, and enter WAIT.
REQ-009 In WAIT, mem_req and mem_addr SHALL hold stable until mem_ack is sampled high.
REQ-010 On the edge that samples mem_ack=1 in WAIT: instr<=mem_rdata, instr_valid<=1, mem_req<=0, state<=IDLE. Latency is one cycle from ack to instr_valid.
REQ-011 mem_ack while in IDLE SHALL be ignored.
REQ-012 do_fetch while in WAIT SHALL be ignored.
REQ-013 do_next in IDLE SHALL set pc<=branch_taken ? branch_target : pc+1 (modulo 2^ADDR_WIDTH) and clear instr_valid.
REQ-014 do_next in WAIT SHALL set a pending flag and capture the target; the PC update and instr_valid clear SHALL be applied on the ack edge, after the instruction load.
REQ-015 do_reset SHALL take priority over every other input: pc<=0, instr<=0, instr_valid<=0, mem_req<=0, pending cleared, state<=IDLE. An ack in the same cycle SHALL be discarded.
REQ-016 do_halt high SHALL block new requests. An outstanding request SHALL still complete normally.
REQ-017 opcode SHALL equal instr[INSTR_WIDTH-1 -: OPCODE_SIZE], combinational.
REQ-018 is_alu_operation SHALL equal instr_valid && (opcode <= ALU_OPCODE_MAX).
REQ-019 fetch_stall SHALL be high exactly while state==WAIT.

Reset
REQ-020 reset_n low SHALL asynchronously force: pc=0, instr=0, instr_valid=0, mem_req=0, mem_addr=0, pending=0, state=IDLE, timeout counter=0, fetch_fault=0.
REQ-021 Release of reset_n SHALL take effect on the first clock edge after deassertion.

Configuration
REQ-022 With FETCH_TIMEOUT_EN defined, the block SHALL add:
  - a 4-bit counter running in WAIT;
  - an output port fetch_fault (1 bit).
  After 16 consecutive WAIT cycles without ack: mem_req<=0, instr<={HALT_OPCODE, zeros}, instr_valid<=1, fetch_fault<=1 (sticky until reset_n or do_reset), state<=IDLE.
REQ-023 With FETCH_TIMEOUT_EN undefined, WAIT SHALL persist indefinitely, and neither the fetch_fault port nor the counter SHALL exist.

Verification
REQ-024 Reset then do_fetch, mem_ack after 2 cycles with mem_rdata=16'h3012 -> mem_addr=0 held for 3 cycles; instr=16'h3012, opcode=3, is_alu_operation=1, instr_valid=1.
REQ-025 pc=8'hFF, do_next with branch_taken=0 -> pc=8'h00, instr_valid=0.
REQ-026 do_next with branch_taken=1, branch_target=8'h40 issued during WAIT, ack 3 cycles later -> instr loaded from the old pc, then pc=8'h40 on the same edge.
REQ-027 do_reset coincident with mem_ack -> instr=0, pc=0, mem_req=0, ack discarded.
REQ-028 FETCH_TIMEOUT_EN defined, no ack for 16 cycles -> fetch_fault=1, opcode=4'hF, mem_req=0. Without the macro, mem_req remains 1 after 100 cycles.
